// File: rtl/sim_axi_mem_pkg.sv
// ============================================================================
// Module   : sim_axi_mem_pkg
// Brief    : Shared constants, FSM state types and response helpers for the
//            pure-RTL AXI4 slave memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_axi_mem_pkg;

    localparam logic [1:0] c_FIXED  = 2'd0;
    localparam logic [1:0] c_INCR   = 2'd1;
    localparam logic [1:0] c_WRAP   = 2'd2;

    localparam logic [1:0] c_OKAY   = 2'd0;
    localparam logic [1:0] c_SLVERR = 2'd2;
    localparam logic [1:0] c_DECERR = 2'd3;

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WWAIT = 2'd2,
        WRESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RIDLE = 2'd0,
        RWAIT = 2'd1,
        RDATA = 2'd2
    } rd_state_t;

    // Severity rank: DECERR > SLVERR > OKAY.
    function automatic logic [1:0] resp_rank(input logic [1:0] resp);
        case (resp)
            c_DECERR: return 2'd2;
            c_SLVERR: return 2'd1;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (resp_rank(a) >= resp_rank(b)) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sim_axi_mem_addr_gen.sv
// ============================================================================
// Module   : sim_axi_mem_addr_gen
// Brief    : Per-beat address stepping, range decode and request legality.
//            WRAP bursts are legal only with SIM_AXI_MEM_WRAP_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_axi_mem_addr_gen
    import sim_axi_mem_pkg::*;
#(
    parameter int                   ADDR_BITS   = 32,
    parameter int                   DATA_BITS   = 64,
    parameter int                   DEPTH_WORDS = 4096,
    parameter logic [ADDR_BITS-1:0] MEM_BASE    = '0
) (
    input  logic [ADDR_BITS-1:0]           i_addr,
    input  logic [7:0]                     i_len,
    input  logic [2:0]                     i_size,
    input  logic [1:0]                     i_burst,
    output logic [ADDR_BITS-1:0]           o_next_addr,
    output logic [$clog2(DEPTH_WORDS)-1:0] o_word_idx,
    output logic [1:0]                     o_beat_resp
);

    localparam int          c_LANE_BITS = $clog2(DATA_BITS / 8);
    localparam int          c_IDX_BITS  = $clog2(DEPTH_WORDS);
    localparam logic [63:0] c_BASE      = 64'(MEM_BASE);
    localparam logic [63:0] c_SPAN      = 64'(DEPTH_WORDS) * 64'(DATA_BITS / 8);
`ifdef SIM_AXI_MEM_WRAP_BURST_EN
    localparam logic        c_WRAP_EN   = 1'b1;
`else
    localparam logic        c_WRAP_EN   = 1'b0;
`endif

    logic [63:0]          w_off;
    logic                 w_in_range;
    logic                 w_wrap_ok;
    logic                 w_bad_req;
    logic [ADDR_BITS-1:0] w_incr;
    logic [ADDR_BITS-1:0] w_mask;

    always_comb begin
        w_off       = 64'(i_addr) - c_BASE;
        w_in_range  = (64'(i_addr) >= c_BASE) && (w_off < c_SPAN);
        o_word_idx  = w_off[c_LANE_BITS +: c_IDX_BITS];
        w_incr      = ADDR_BITS'(1) << i_size;
        // Container is (len+1) beats of 2^size bytes, always a power of two when legal.
        w_mask      = ((ADDR_BITS'(i_len) + ADDR_BITS'(1)) << i_size) - ADDR_BITS'(1);
        w_wrap_ok   = c_WRAP_EN && ((i_len == 8'd1) || (i_len == 8'd3) ||
                                    (i_len == 8'd7) || (i_len == 8'd15));
        w_bad_req   = (i_size > 3'(c_LANE_BITS)) || (i_burst == 2'd3) ||
                      ((i_burst == c_WRAP) && !w_wrap_ok);

        if (!w_in_range)    o_beat_resp = c_DECERR;
        else if (w_bad_req) o_beat_resp = c_SLVERR;
        else                o_beat_resp = c_OKAY;

        case (i_burst)
            c_FIXED: o_next_addr = i_addr;
            c_INCR:  o_next_addr = i_addr + w_incr;
            c_WRAP:  o_next_addr = w_wrap_ok ? ((i_addr & ~w_mask) | ((i_addr + w_incr) & w_mask))
                                             : (i_addr + w_incr);
            default: o_next_addr = i_addr;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sim_axi_mem_model.sv
// ============================================================================
// Module   : sim_axi_mem_model
// Brief    : Array-backed AXI4 slave memory with fixed read/write latency,
//            one outstanding burst per direction. Macro: SIM_AXI_MEM_WRAP_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_axi_mem_model
    import sim_axi_mem_pkg::*;
#(
    parameter int                   ADDR_BITS     = 32,
    parameter int                   DATA_BITS     = 64,
    parameter int                   ID_BITS       = 5,
    parameter int                   DEPTH_WORDS   = 4096,
    parameter logic [ADDR_BITS-1:0] MEM_BASE      = '0,
    parameter int                   READ_LATENCY  = 4,
    parameter int                   WRITE_LATENCY = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     aw_valid,
    output logic                     aw_ready,
    input  logic [ADDR_BITS-1:0]     aw_addr,
    input  logic [ID_BITS-1:0]       aw_id,
    input  logic [7:0]               aw_len,
    input  logic [2:0]               aw_size,
    input  logic [1:0]               aw_burst,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [DATA_BITS-1:0]     w_data,
    input  logic [DATA_BITS/8-1:0]   w_strb,
    input  logic                     w_last,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [ID_BITS-1:0]       b_id,
    output logic [1:0]               b_resp,
    input  logic                     ar_valid,
    output logic                     ar_ready,
    input  logic [ADDR_BITS-1:0]     ar_addr,
    input  logic [ID_BITS-1:0]       ar_id,
    input  logic [7:0]               ar_len,
    input  logic [2:0]               ar_size,
    input  logic [1:0]               ar_burst,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [DATA_BITS-1:0]     r_data,
    output logic [ID_BITS-1:0]       r_id,
    output logic [1:0]               r_resp,
    output logic                     r_last
);

    localparam int c_BYTES    = DATA_BITS / 8;
    localparam int c_IDX_BITS = $clog2(DEPTH_WORDS);

    logic [DATA_BITS-1:0] r_mem [DEPTH_WORDS];

    wr_state_t             r_wr_state;
    logic [ADDR_BITS-1:0]  r_wr_addr;
    logic [ID_BITS-1:0]    r_wr_id;
    logic [7:0]            r_wr_len, r_wr_beat, r_wr_cnt;
    logic [2:0]            r_wr_size;
    logic [1:0]            r_wr_burst, r_wr_err;
    logic                  r_aw_ready, r_w_ready, r_b_valid;
    logic [ID_BITS-1:0]    r_b_id;
    logic [1:0]            r_b_resp;

    rd_state_t             r_rd_state;
    logic [ADDR_BITS-1:0]  r_rd_addr;
    logic [ID_BITS-1:0]    r_rd_id;
    logic [7:0]            r_rd_len, r_rd_beat, r_rd_cnt;
    logic [2:0]            r_rd_size;
    logic [1:0]            r_rd_burst;
    logic                  r_ar_ready, r_r_valid, r_r_last;
    logic [DATA_BITS-1:0]  r_r_data;
    logic [ID_BITS-1:0]    r_r_id;
    logic [1:0]            r_r_resp;

    logic [ADDR_BITS-1:0]  w_wr_next, w_rd_next;
    logic [c_IDX_BITS-1:0] w_wr_idx, w_rd_idx;
    logic [1:0]            w_wr_resp, w_rd_resp;
    logic                  w_w_fire, w_wr_last_beat, w_mem_we;

    sim_axi_mem_addr_gen #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .DEPTH_WORDS(DEPTH_WORDS), .MEM_BASE(MEM_BASE)
    ) u_wr_addr_gen (
        .i_addr(r_wr_addr), .i_len(r_wr_len), .i_size(r_wr_size), .i_burst(r_wr_burst),
        .o_next_addr(w_wr_next), .o_word_idx(w_wr_idx), .o_beat_resp(w_wr_resp)
    );

    sim_axi_mem_addr_gen #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .DEPTH_WORDS(DEPTH_WORDS), .MEM_BASE(MEM_BASE)
    ) u_rd_addr_gen (
        .i_addr(r_rd_addr), .i_len(r_rd_len), .i_size(r_rd_size), .i_burst(r_rd_burst),
        .o_next_addr(w_rd_next), .o_word_idx(w_rd_idx), .o_beat_resp(w_rd_resp)
    );

    assign w_w_fire       = (r_wr_state == WDATA) && w_valid && r_w_ready;
    assign w_wr_last_beat = (r_wr_beat == r_wr_len);
    assign w_mem_we       = w_w_fire && (w_wr_resp == c_OKAY) && !reset;

    // Storage is deliberately outside reset: contents survive a harness reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (w_strb[b]) r_mem[w_wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_state <= WIDLE;
            r_wr_addr  <= '0;
            r_wr_id    <= '0;
            r_wr_len   <= '0;
            r_wr_beat  <= '0;
            r_wr_cnt   <= '0;
            r_wr_size  <= '0;
            r_wr_burst <= '0;
            r_wr_err   <= c_OKAY;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_id     <= '0;
            r_b_resp   <= '0;
        end else begin
            case (r_wr_state)
                WIDLE: begin
                    if (aw_valid && r_aw_ready) begin
                        r_wr_addr  <= aw_addr;
                        r_wr_id    <= aw_id;
                        r_wr_len   <= aw_len;
                        r_wr_size  <= aw_size;
                        r_wr_burst <= aw_burst;
                        r_wr_beat  <= '0;
                        r_wr_err   <= c_OKAY;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b1;
                        r_wr_state <= WDATA;
                    end else begin
                        r_aw_ready <= 1'b1;
                    end
                end
                WDATA: begin
                    if (w_w_fire) begin
                        r_wr_err  <= resp_max(resp_max(r_wr_err, w_wr_resp),
                                              (w_last != w_wr_last_beat) ? c_SLVERR : c_OKAY);
                        r_wr_addr <= w_wr_next;
                        r_wr_beat <= r_wr_beat + 8'd1;
                        // Beat count, not w_last, ends the data phase.
                        if (w_wr_last_beat) begin
                            r_w_ready  <= 1'b0;
                            r_wr_cnt   <= '0;
                            r_wr_state <= WWAIT;
                        end
                    end
                end
                WWAIT: begin
                    if (r_wr_cnt == 8'(WRITE_LATENCY)) begin
                        r_b_valid  <= 1'b1;
                        r_b_id     <= r_wr_id;
                        r_b_resp   <= r_wr_err;
                        r_wr_state <= WRESP;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + 8'd1;
                    end
                end
                WRESP: begin
                    if (b_ready) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_wr_state <= WIDLE;
                    end
                end
                default: r_wr_state <= WIDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_state <= RIDLE;
            r_rd_addr  <= '0;
            r_rd_id    <= '0;
            r_rd_len   <= '0;
            r_rd_beat  <= '0;
            r_rd_cnt   <= '0;
            r_rd_size  <= '0;
            r_rd_burst <= '0;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_last   <= 1'b0;
            r_r_data   <= '0;
            r_r_id     <= '0;
            r_r_resp   <= '0;
        end else begin
            case (r_rd_state)
                RIDLE: begin
                    if (ar_valid && r_ar_ready) begin
                        r_rd_addr  <= ar_addr;
                        r_rd_id    <= ar_id;
                        r_rd_len   <= ar_len;
                        r_rd_size  <= ar_size;
                        r_rd_burst <= ar_burst;
                        r_rd_beat  <= '0;
                        r_rd_cnt   <= '0;
                        r_ar_ready <= 1'b0;
                        r_rd_state <= RWAIT;
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                RWAIT: begin
                    if (r_rd_cnt == 8'(READ_LATENCY)) r_rd_state <= RDATA;
                    else                             r_rd_cnt   <= r_rd_cnt + 8'd1;
                end
                RDATA: begin
                    // A beat is loaded while r_valid is low, then held until it fires.
                    if (!r_r_valid) begin
                        r_r_valid <= 1'b1;
                        r_r_data  <= (w_rd_resp == c_OKAY) ? r_mem[w_rd_idx] : '0;
                        r_r_resp  <= w_rd_resp;
                        r_r_id    <= r_rd_id;
                        r_r_last  <= (r_rd_beat == r_rd_len);
                    end else if (r_ready) begin
                        r_r_valid <= 1'b0;
                        if (r_r_last) begin
                            r_r_last   <= 1'b0;
                            r_rd_state <= RIDLE;
                        end else begin
                            r_rd_addr <= w_rd_next;
                            r_rd_beat <= r_rd_beat + 8'd1;
                        end
                    end
                end
                default: r_rd_state <= RIDLE;
            endcase
        end
    end

    assign aw_ready = r_aw_ready;
    assign w_ready  = r_w_ready;
    assign b_valid  = r_b_valid;
    assign b_id     = r_b_id;
    assign b_resp   = r_b_resp;
    assign ar_ready = r_ar_ready;
    assign r_valid  = r_r_valid;
    assign r_data   = r_r_data;
    assign r_id     = r_r_id;
    assign r_resp   = r_r_resp;
    assign r_last   = r_r_last;

endmodule

`default_nettype wire

// File: tb/tb_sim_axi_mem_model.sv
// ============================================================================
// Module   : tb_sim_axi_mem_model
// Brief    : Directed self-checking bench for sim_axi_mem_model (64-bit data).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_axi_mem_model;

    logic        clock, reset;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [31:0] aw_addr, ar_addr;
    logic [4:0]  aw_id, ar_id, b_id, r_id;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [63:0] w_data, r_data;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] wbuf    [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic [4:0]  rd_id   [16];
    logic        rd_last [16];

    sim_axi_mem_model #(
        .ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(5), .DEPTH_WORDS(4096),
        .MEM_BASE(32'h0), .READ_LATENCY(4), .WRITE_LATENCY(2)
    ) dut (
        .clock(clock), .reset(reset),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
        .r_resp(r_resp), .r_last(r_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [4:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                             input int last_at, output logic [1:0] resp, output logic [4:0] rid);
        int t;
        aw_addr = addr; aw_id = id; aw_len = len; aw_size = size; aw_burst = burst;
        aw_valid = 1'b1; t = 0;
        @(negedge clock);
        while (!aw_ready && t < 200) begin @(negedge clock); t++; end
        if (t >= 200) chk("aw_timeout", 64'd1, 64'd0);
        @(posedge clock); #1 aw_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_valid = 1'b1; w_data = wbuf[i]; w_strb = strb; w_last = (i == last_at);
            t = 0;
            @(negedge clock);
            while (!w_ready && t < 200) begin @(negedge clock); t++; end
            if (t >= 200) chk("w_timeout", 64'd1, 64'd0);
            @(posedge clock); #1;
        end
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b1; t = 0;
        @(negedge clock);
        while (!b_valid && t < 200) begin @(negedge clock); t++; end
        if (t >= 200) chk("b_timeout", 64'd1, 64'd0);
        resp = b_resp; rid = b_id;
        @(posedge clock); #1 b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [4:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int nbeats);
        int t;
        ar_addr = addr; ar_id = id; ar_len = len; ar_size = size; ar_burst = burst;
        ar_valid = 1'b1; t = 0; nbeats = 0;
        @(negedge clock);
        while (!ar_ready && t < 200) begin @(negedge clock); t++; end
        if (t >= 200) chk("ar_timeout", 64'd1, 64'd0);
        @(posedge clock); #1 ar_valid = 1'b0;
        r_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            t = 0;
            @(negedge clock);
            while (!r_valid && t < 200) begin @(negedge clock); t++; end
            if (t >= 200) begin chk("r_timeout", 64'd1, 64'd0); break; end
            rd_data[i] = r_data; rd_resp[i] = r_resp; rd_last[i] = r_last; rd_id[i] = r_id;
            nbeats++;
            @(posedge clock); #1;
            if (rd_last[i]) break;
        end
        r_ready = 1'b0;
    endtask

    function automatic logic [15:0] last_mask(input int n);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = rd_last[i];
        return m;
    endfunction

    initial begin
        logic [1:0]  resp;
        logic [4:0]  rid;
        logic [63:0] held_data;
        logic [4:0]  held_id;
        logic        held_last;
        int          nb, cyc, t;

        reset = 1'b1; aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
        aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        w_data = 0; w_strb = 0; w_last = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_handshakes", 64'({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last}), 64'd0);
        chk("rst_rdata", r_data, 64'd0);
        chk("rst_ids_resps", 64'({b_id, b_resp, r_id, r_resp}), 64'd0);
        @(negedge clock) reset = 1'b0;

        // INCR write/readback
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
        axi_write(32'h100, 5'd5, 8'd3, 3'd3, 2'd1, 8'hFF, 3, resp, rid);
        chk("incr_bresp", 64'(resp), 64'd0);
        chk("incr_bid", 64'(rid), 64'd5);
        axi_read(32'h100, 5'd9, 8'd3, 3'd3, 2'd1, nb);
        chk("incr_nbeats", 64'(nb), 64'd4);
        chk("incr_d0", rd_data[0], 64'h11);
        chk("incr_d1", rd_data[1], 64'h22);
        chk("incr_d2", rd_data[2], 64'h33);
        chk("incr_d3", rd_data[3], 64'h44);
        chk("incr_rlast", 64'(last_mask(4)), 64'h8);
        chk("incr_rresp", 64'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 64'd0);
        chk("incr_rid", 64'(rd_id[3]), 64'd9);

        // Read latency and hold-while-stalled
        ar_addr = 32'h108; ar_id = 5'd3; ar_len = 8'd0; ar_size = 3'd3; ar_burst = 2'd1;
        ar_valid = 1'b1; r_ready = 1'b0; t = 0;
        @(negedge clock);
        while (!ar_ready && t < 200) begin @(negedge clock); t++; end
        @(posedge clock); #1 ar_valid = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1; cyc++;
            if (r_valid) break;
        end
        chk("rd_latency", 64'(cyc), 64'd6);
        held_data = r_data; held_id = r_id; held_last = r_last;
        chk("lat_data", held_data, 64'h22);
        repeat (3) @(posedge clock);
        #1;
        chk("stall_valid", 64'(r_valid), 64'd1);
        chk("stall_stable", 64'({r_data == held_data, r_id == held_id, r_last == held_last}), 64'h7);
        chk("stall_id_last", 64'({r_id, r_last}), 64'({5'd3, 1'b1}));
        r_ready = 1'b1;
        @(posedge clock); #1 r_ready = 1'b0;
        chk("lat_done", 64'(r_valid), 64'd0);

        // Byte strobes
        wbuf[0] = 64'hFFFFFFFF_FFFFFFFF;
        axi_write(32'h200, 5'd1, 8'd0, 3'd3, 2'd1, 8'hFF, 0, resp, rid);
        wbuf[0] = 64'hAABBCCDD_11223344;
        axi_write(32'h200, 5'd1, 8'd0, 3'd3, 2'd1, 8'h0F, 0, resp, rid);
        axi_read(32'h200, 5'd1, 8'd0, 3'd3, 2'd1, nb);
        chk("strb_data", rd_data[0], 64'hFFFFFFFF_11223344);

        // Out-of-range and w_last mismatch
        axi_read(32'h8000, 5'd2, 8'd0, 3'd3, 2'd1, nb);
        chk("oob_rresp", 64'(rd_resp[0]), 64'd3);
        chk("oob_rdata", rd_data[0], 64'd0);
        wbuf[0] = 64'h1; wbuf[1] = 64'h2; wbuf[2] = 64'h3; wbuf[3] = 64'h4;
        axi_write(32'h8000, 5'd4, 8'd0, 3'd3, 2'd1, 8'hFF, 0, resp, rid);
        chk("oob_bresp", 64'(resp), 64'd3);
        axi_write(32'h300, 5'd6, 8'd3, 3'd3, 2'd1, 8'hFF, 1, resp, rid);
        chk("wlast_bresp", 64'(resp), 64'd2);
        axi_read(32'h318, 5'd6, 8'd0, 3'd3, 2'd1, nb);
        chk("wlast_beat4_written", rd_data[0], 64'h4);
        axi_read(32'h100, 5'd7, 8'd0, 3'd4, 2'd1, nb);
        chk("size_err_rresp", 64'(rd_resp[0]), 64'd2);

        // WRAP burst
        axi_read(32'h118, 5'd8, 8'd3, 3'd3, 2'd2, nb);
        chk("wrap_nbeats", 64'(nb), 64'd4);
        chk("wrap_rlast", 64'(last_mask(4)), 64'h8);
`ifdef SIM_AXI_MEM_WRAP_BURST_EN
        chk("wrap_d", {rd_data[0][15:0], rd_data[1][15:0], rd_data[2][15:0], rd_data[3][15:0]},
            64'h0044_0011_0022_0033);
        chk("wrap_resp", 64'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 64'd0);
`else
        chk("wrap_d", rd_data[0] | rd_data[1] | rd_data[2] | rd_data[3], 64'd0);
        chk("wrap_resp", 64'({rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}), 64'hAA);
`endif

        // Reset during beat 2 of a read burst
        ar_addr = 32'h100; ar_id = 5'd2; ar_len = 8'd3; ar_size = 3'd3; ar_burst = 2'd1;
        ar_valid = 1'b1; t = 0;
        @(negedge clock);
        while (!ar_ready && t < 200) begin @(negedge clock); t++; end
        @(posedge clock); #1 ar_valid = 1'b0; r_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            @(negedge clock);
            while (!r_valid && t < 200) begin @(negedge clock); t++; end
            if (t >= 200) chk("rst_mid_timeout", 64'd1, 64'd0);
            if (k == 0) begin @(posedge clock); #1; end
        end
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid_rvalid", 64'(r_valid), 64'd0);
        r_ready = 1'b0;
        @(negedge clock) reset = 1'b0;
        axi_read(32'h100, 5'd1, 8'd3, 3'd3, 2'd1, nb);
        chk("post_rst_nbeats", 64'(nb), 64'd4);
        chk("post_rst_d0", rd_data[0], 64'h11);
        chk("post_rst_d3", rd_data[3], 64'h44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sim_axi_mem_model.md
Name: sim_axi_mem_model

Overview:
- Pure-RTL AXI4 slave memory model for simulation harnesses. Needs no DPI and no C++ backing store, so it suits simulators without DPI and multi-channel tops.
- Array-backed storage.
- Supports FIXED/INCR bursts, narrow transfers and byte strobes.
- Fixed, parametrised read and write latency; error responses for bad requests.
- Sits at the memory port of the test harness in place of the DPI-backed DRAM model.

Parameters:
- ADDR_BITS, 32, AXI address width
- DATA_BITS, 64, data bus width; power of two, 32..512
- ID_BITS, 5, AXI ID width
- DEPTH_WORDS, 4096, number of DATA_BITS-wide words stored
- MEM_BASE, 0, byte address of word 0; aligned to DATA_BITS/8
- READ_LATENCY, 4, cycles from AR handshake to first R valid beyond the minimum; 0..255
- WRITE_LATENCY, 2, cycles from last W handshake to B valid beyond the minimum; 0..255

Ports:
- clock, in, 1, clock
- reset, in, 1, synchronous, active-high reset
- aw_valid/aw_ready, in/out, 1/1, AW handshake
- aw_addr, in, ADDR_BITS, byte address
- aw_id, in, ID_BITS, transaction ID
- aw_len, in, 8, burst beats minus one
- aw_size, in, 3, log2 of bytes per beat
- aw_burst, in, 2, burst type
- w_valid/w_ready, in/out, 1/1, W handshake
- w_data, in, DATA_BITS, write data
- w_strb, in, DATA_BITS/8, byte enables
- w_last, in, 1, last beat
- b_valid/b_ready, out/in, 1/1, B handshake
- b_id, out, ID_BITS, response ID
- b_resp, out, 2, write response
- ar_valid/ar_ready, ar_addr, ar_id, ar_len, ar_size, ar_burst: as the AW group
- r_valid/r_ready, out/in, 1/1, R handshake
- r_data, out, DATA_BITS, read data
- r_id, out, ID_BITS, response ID
- r_resp, out, 2, read response
- r_last, out, 1, last beat

Behaviour:

Reset and concurrency:
- While reset is high, all valid/ready outputs are 0 and r_data/r_id/r_resp/b_id/b_resp are 0.
- Memory contents are not cleared by reset.
- Reset mid-burst aborts both FSMs to idle and drops partial responses. Beats already written stay written.
- One outstanding read burst and one outstanding write burst at a time. The read and write FSMs are independent.

Write FSM: WIDLE -> WDATA -> WWAIT -> WRESP
- WIDLE: aw_ready=1. On AW fire, capture addr/id/len/size/burst, beat=0, err=OKAY, go to WDATA.
- WDATA: w_ready=1.
  - Each fire writes the strobed bytes to word (addr-MEM_BASE)>>log2(DATA_BITS/8) at that edge.
  - Then advance addr: FIXED keeps it; INCR adds 1<<size.
  - On beat==len go to WWAIT, regardless of w_last.
  - w_last mismatch on any beat sets err=SLVERR.
- WWAIT: counts WRITE_LATENCY cycles; 0 means straight to WRESP next cycle.
- WRESP: b_valid=1 with captured id and err, held until b_ready; then WIDLE.

Read FSM: RIDLE -> RWAIT -> RDATA
- RIDLE: ar_ready=1. Capture on fire.
- RWAIT: counts READ_LATENCY cycles.
- RDATA:
  - r_valid=1; r_data is registered from the array when the beat is presented.
  - All R outputs are held stable while r_valid && !r_ready.
  - On fire, advance addr and beat.
  - r_last=1 when beat==len; its fire returns to RIDLE.

Ordering:
- A read beat sees writes committed on earlier edges, not a write on the same edge.

Errors (per beat):
- Address outside [MEM_BASE, MEM_BASE+DEPTH_WORDS*DATA_BITS/8): DECERR, write suppressed, read data 0.
- size > log2(DATA_BITS/8), or burst=3: SLVERR, no access.
- B returns the highest-severity error seen during the burst: DECERR > SLVERR > OKAY.

Width rules:
- Address arithmetic is done in ADDR_BITS and wraps modulo 2^ADDR_BITS.
- Latency counters are 8 bits.

Optional Feature:
- Macro SIM_AXI_MEM_WRAP_BURST_EN.
- With it: burst=2 (WRAP) is legal for len in {1,3,7,15}.
  - Container = (len+1)<<size.
  - Address wraps to the container-aligned base when it crosses the container boundary.
  - Other len values give SLVERR.
- Without it: WRAP returns SLVERR on every beat with no access. Reads return 0 with the correct beat count and r_last.

Decomposition:
- Package sim_axi_mem_pkg holds:
  - burst type constants FIXED=0, INCR=1, WRAP=2;
  - resp constants OKAY=0, SLVERR=2, DECERR=3;
  - write and read FSM state enums;
  - helper for resp severity max.
- Sub-module sim_axi_mem_addr_gen computes the next address, range check and size error. It is combinational and instantiated once per FSM.

Test Plan:
- Write INCR len=3 size=3 at 0x100 with data 0x11..0x44, full strobes; then read the same range -> r_data 0x11,0x22,0x33,0x44 in order, r_last only on beat 4, b_resp=OKAY.
- READ_LATENCY=4, single-beat read -> r_valid rises exactly 6 cycles after the AR fire edge; r_ready held low for 3 cycles -> r_data/r_id/r_last stay stable.
- Write w_strb=0x0F, data 0xAABBCCDD_11223344 over a word holding 0xFFFFFFFF_FFFFFFFF -> readback 0xFFFFFFFF_11223344.
- Read at MEM_BASE+DEPTH_WORDS*8 -> r_resp=DECERR, r_data=0. Write with w_last asserted on beat 1 of len=3 -> b_resp=SLVERR after 4 beats.
- WRAP len=3 size=3 starting at 0x118:
  - with macro -> beats access 0x118, 0x100, 0x108, 0x110;
  - without macro -> 4 beats with SLVERR.
- Assert reset during beat 2 of a read burst -> r_valid=0 the next cycle; a new AR is accepted after reset; memory is unchanged.
